jk_latch_driver: RTL and testbench
==================================

Name: jk_latch_driver

Overview:
- Drives a WIDTH-bit bank of jk_latch instances toward a requested target word.
- Accepts target words over a valid/ready handshake and samples the bank's current q.
- Derives per-bit j/k from the JK excitation table and pulses the latch enable (clk input of the bank).
- Waits for settle, reads q back, and reports completion plus per-bit mismatch. This is the encode/drive side that sits in front of the latch bank.

Parameters:
- WIDTH, 8, number of latches in the driven bank.
- EN_CYCLES, 1, cycles the latch enable is held high per update; must be >= 1.
- SETTLE_CYCLES, 2, idle cycles after enable deasserts before readback; 0 is legal.
- HOLD_SKIP, 1, if 1, a target equal to the sampled q completes without an enable pulse.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  target word offered.
- in_ready  out  1  driver can accept a target; high only in IDLE.
- in_target  in  WIDTH  requested latch-bank state.
- q_fb  in  WIDTH  q outputs of the latch bank.
- j  out  WIDTH  j inputs to the bank.
- k  out  WIDTH  k inputs to the bank.
- en  out  1  latch enable, connected to the bank's clk pin.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 if any bit mismatched at readback. Held until the next accept.
- err_mask  out  WIDTH  per-bit mismatch (q_fb xor target) at readback. Held until the next accept.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - j = k = 0, en = 0, done = 0, err = 0, err_mask = 0, busy = 0, in_ready = 1.
  - Counters and captured registers are cleared.
  - Reset mid-update abandons the update immediately: en drops in the same instant and no done is issued.
- All outputs are registered. No combinational path exists from in_valid or q_fb to any output.
- Accept: in IDLE with in_valid = 1 (cycle 0):
  - Capture tgt = in_target and cur = q_fb.
  - Clear err and err_mask.
- Excitation, per bit:
  - cur 0 -> tgt 0: j = 0, k = 0.
  - cur 0 -> tgt 1: j = 1, k = 0.
  - cur 1 -> tgt 0: j = 0, k = 1.
  - cur 1 -> tgt 1: j = 0, k = 0.
  - Don't-care inputs are always driven 0. j = k = 1 (toggle) is never driven, which avoids race-around while en is high for several cycles.
- FSM states are IDLE, DRIVE, SETTLE, CHECK and REPORT.
  - IDLE -> DRIVE on accept.
  - IDLE -> REPORT on accept when HOLD_SKIP = 1 and tgt == cur. No en pulse, err = 0, err_mask = 0.
  - DRIVE: j/k hold the excitation and en = 1 for exactly EN_CYCLES cycles (cycles 1..EN_CYCLES). Then go to SETTLE, or to CHECK if SETTLE_CYCLES = 0.
  - SETTLE: en = 0 and j = k = 0 for SETTLE_CYCLES cycles, then go to CHECK.
  - CHECK: one cycle. Compute mism = q_fb xor tgt, register err_mask = mism and err = |mism, assert done next cycle, and go to IDLE. REPORT is folded into the CHECK -> IDLE transition.
  - REPORT (skip path only): done = 1 in cycle 1, then IDLE.
- Latency, accept to done:
  - Normal path: EN_CYCLES + SETTLE_CYCLES + 2 cycles (5 with defaults).
  - Skip path: 1 cycle.
- done coincides with in_ready = 1. A target held valid in that cycle is accepted, giving back-to-back updates with no gap.
- in_target and in_valid are ignored outside IDLE. The upstream must hold its data until in_ready = 1.
- Counter width is $clog2(max(EN_CYCLES, SETTLE_CYCLES) + 1).
- X or unknown on q_fb at accept is treated bitwise as sampled. After reset the bank state is unknown, so the first update should target a fully defined word; its readback establishes a known state.

Decomposition:
- Shared package jk_drv_pkg holds:
  - the state enum (IDLE, DRIVE, SETTLE, CHECK, REPORT);
  - localparams for the excitation encodings (JK_HOLD, JK_SET, JK_RESET).
- One sub-module, jk_excite: purely combinational, WIDTH-parameterised. It maps (cur, tgt) to (j, k) per the table above. The driver instantiates it once.

Test Plan (bench uses WIDTH = 4, with 4 jk_latch instances as the bank):
- Reset: assert rst mid-DRIVE -> en, j, k, done, err drop to 0 immediately; in_ready = 1 after release; no done.
- Bank at 4'b0000, target 4'b1010 -> j = 1010, k = 0000, en high exactly 1 cycle; done at cycle 5; q_fb = 1010; err = 0.
- From 4'b1010, target 4'b0110 -> j = 0100, k = 1000; done with err = 0, err_mask = 0000.
- HOLD_SKIP: target equals q_fb = 4'b0110 -> no en pulse, done at cycle 1, err = 0.
- Fault: force latch bit 0 stuck at 0, target 4'b0001 -> done with err = 1, err_mask = 4'b0001.
- Back-to-back: in_valid held with targets 4'hF then 4'h0 -> second accepted in the done cycle of the first; both complete with err = 0; j & k is never nonzero.

Source files
------------

// File: rtl/jk_drv_pkg.sv
// Shared types for the JK latch-bank driver: FSM state encoding and the
// {j,k} excitation codes used to move one latch between states.
package jk_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    REPORT
  } state_e;

  // Encodings are {j, k}; the toggle code 2'b11 is deliberately absent.
  localparam logic [1:0] JK_HOLD  = 2'b00;
  localparam logic [1:0] JK_SET   = 2'b10;
  localparam logic [1:0] JK_RESET = 2'b01;

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation: maps (current q, wanted q) to the j/k pair that
// moves the latch there, never requesting a toggle.
module jk_excite
  import jk_drv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] tgt_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o
);

  always_comb begin
    j_o = '0;
    k_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      // Unknown current bits fall into the hold code, so X never turns into a pulse.
      case ({cur_i[i], tgt_i[i]})
        2'b01:   {j_o[i], k_o[i]} = JK_SET;
        2'b10:   {j_o[i], k_o[i]} = JK_RESET;
        default: {j_o[i], k_o[i]} = JK_HOLD;
      endcase
    end
  end

endmodule

// File: rtl/jk_latch_driver.sv
// Drives a bank of JK latches toward a requested word: encode, pulse the
// latch enable, wait for settle, then read back and flag mismatching bits.
module jk_latch_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int EN_CYCLES     = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int HOLD_SKIP     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  localparam int CNT_MAX = (EN_CYCLES > SETTLE_CYCLES) ? EN_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] EN_LOAD  = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] err_mask_q, err_mask_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] exc_cur, exc_tgt, exc_j, exc_k;

  // At accept the excitation must come from the live inputs; afterwards from the captured pair.
  assign exc_cur = (state_q == IDLE) ? q_fb      : cur_q;
  assign exc_tgt = (state_q == IDLE) ? in_target : tgt_q;

  jk_excite #(
    .WIDTH(WIDTH)
  ) u_excite (
    .cur_i(exc_cur),
    .tgt_i(exc_tgt),
    .j_o  (exc_j),
    .k_o  (exc_k)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    cur_d      = cur_q;
    j_d        = j_q;
    k_d        = k_q;
    en_d       = en_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_mask_d = err_mask_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          tgt_d      = in_target;
          cur_d      = q_fb;
          err_d      = 1'b0;
          err_mask_d = '0;
          if ((HOLD_SKIP != 0) && (in_target == q_fb)) begin
            state_d = REPORT;
            done_d  = 1'b1;
          end else begin
            state_d = DRIVE;
            cnt_d   = EN_LOAD;
            j_d     = exc_j;
            k_d     = exc_k;
            en_d    = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          en_d = 1'b0;
          j_d  = '0;
          k_d  = '0;
          if (SETTLE_CYCLES == 0) begin
            state_d = CHECK;
          end else begin
            state_d = SETTLE;
            cnt_d   = SET_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          j_d   = exc_j;
          k_d   = exc_k;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CHECK: begin
        err_mask_d = q_fb ^ tgt_q;
        err_d      = |(q_fb ^ tgt_q);
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        j_d     = '0;
        k_d     = '0;
      end
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tgt_q      <= '0;
      cur_q      <= '0;
      j_q        <= '0;
      k_q        <= '0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_mask_q <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      cur_q      <= cur_d;
      j_q        <= j_d;
      k_q        <= k_d;
      en_q       <= en_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_mask_q <= err_mask_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign j        = j_q;
  assign k        = k_q;
  assign en       = en_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_mask = err_mask_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_jk_latch_driver.sv
// Bench for jk_latch_driver with a 4-bit behavioural JK latch bank; expected
// completions are queued at accept and checked when done appears.
module tb_jk_latch_driver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_target = '0;
  logic [W-1:0] q_fb;
  logic [W-1:0] j, k;
  logic         en, busy, done, err;
  logic [W-1:0] err_mask;

  logic [W-1:0] bank = '0;
  logic [W-1:0] stuck0 = '0;

  int checks = 0;
  int failures = 0;
  int en_run = 0;

  typedef struct {
    logic         err;
    logic [W-1:0] mask;
    int           lat;
    time          tacc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  jk_latch_driver #(
    .WIDTH(W), .EN_CYCLES(1), .SETTLE_CYCLES(2), .HOLD_SKIP(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_target(in_target), .q_fb(q_fb), .j(j), .k(k), .en(en),
    .busy(busy), .done(done), .err(err), .err_mask(err_mask)
  );

  // Latch bank: transparent while en is high, modelled at mid-cycle.
  assign q_fb = bank & ~stuck0;
  always @(negedge clk) begin
    if (en) begin
      for (int i = 0; i < W; i++) begin
        case ({j[i], k[i]})
          2'b10:   bank[i] <= 1'b1;
          2'b01:   bank[i] <= 1'b0;
          2'b11:   bank[i] <= ~bank[i];
          default: bank[i] <= bank[i];
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: completion scoreboard, enable width and j/k exclusivity.
  always @(negedge clk) begin
    if (!rst) begin
      if (en) begin
        en_run++;
        chk("j_and_k_exclusive", 32'(j & k), 32'h0);
      end else if (en_run != 0) begin
        chk("en_pulse_width", 32'(en_run), 32'd1);
        en_run = 0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_err", 32'(err), 32'(e.err));
          chk("done_err_mask", 32'(err_mask), 32'(e.mask));
          chk("done_latency", 32'(int'(($time - e.tacc + 5) / 10)), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(in_ready && sb.size() == 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(sb.size()), 32'd0);
  endtask

  task automatic send(input logic [W-1:0] tgt, input logic e_err, input logic [W-1:0] e_mask,
                      input int lat, input logic [W-1:0] ej, input logic [W-1:0] ek,
                      input logic een);
    exp_t e;
    wait_ready();
    in_valid  = 1'b1;
    in_target = tgt;
    e.err = e_err; e.mask = e_mask; e.lat = lat; e.tacc = $time + 5;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    chk("drive_en", 32'(en), 32'(een));
    chk("drive_j", 32'(j), 32'(ej));
    chk("drive_k", 32'(k), 32'(ek));
  endtask

  initial begin
    exp_t e;
    int n;
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err_mask", 32'(err_mask), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of DRIVE abandons the update.
    in_valid = 1'b1;
    in_target = 4'b1010;
    @(posedge clk);
    #1;
    chk("mid_en_before_rst", 32'(en), 32'd1);
    chk("mid_j_before_rst", 32'(j), 32'b1010);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_en", 32'(en), 32'd0);
    chk("mid_rst_jk", 32'({j, k}), 32'd0);
    chk("mid_rst_done_err", 32'({done, err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (8) @(negedge clk);
    chk("bank_untouched", 32'(q_fb), 32'b0000);

    // Normal updates.
    send(4'b1010, 1'b0, 4'b0000, 5, 4'b1010, 4'b0000, 1'b1);
    wait_idle();
    chk("bank_1010", 32'(q_fb), 32'b1010);
    send(4'b0110, 1'b0, 4'b0000, 5, 4'b0100, 4'b1000, 1'b1);
    wait_idle();

    // Target already present: no enable pulse.
    send(4'b0110, 1'b0, 4'b0000, 1, 4'b0000, 4'b0000, 1'b0);
    wait_idle();

    // Bit 0 stuck low.
    stuck0 = 4'b0001;
    send(4'b0001, 1'b1, 4'b0001, 5, 4'b0001, 4'b0110, 1'b1);
    wait_idle();
    chk("held_err", 32'(err), 32'd1);
    stuck0 = 4'b0000;
    @(negedge clk);

    // Back-to-back: second target accepted in the done cycle of the first.
    wait_ready();
    in_valid = 1'b1;
    in_target = 4'hF;
    e.err = 1'b0; e.mask = '0; e.lat = 5; e.tacc = $time + 5;
    sb.push_back(e);
    @(negedge clk);
    in_target = 4'h0;
    chk("b2b_first_j", 32'(j), 32'b1110);
    chk("b2b_first_k", 32'(k), 32'b0000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20);
    chk("b2b_done_with_ready", 32'(done), 32'd1);
    e.tacc = $time + 5;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second_en", 32'(en), 32'd1);
    chk("b2b_second_j", 32'(j), 32'b0000);
    chk("b2b_second_k", 32'(k), 32'b1111);
    wait_idle();
    chk("b2b_bank", 32'(q_fb), 32'h0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
